// File: rtl/crop_pixel_packer.sv
// Packs a serial stream of cropped pixels into 256-bit AXIS words, one pixel per lane,
// flagging the last word of every frame and zero-padding a frame's final partial word.
module crop_pixel_packer #(
  parameter int PIXEL_BIT_WIDTH = 10,
  parameter int LANE_WIDTH      = 16,
  parameter int OUT_ROWS        = 20,
  parameter int OUT_COLS        = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic [PIXEL_BIT_WIDTH-1:0] s_axis_tdata,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [255:0]               m_axis_tdata,
  output logic [31:0]                m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [15:0]                frame_count
);

  localparam int PPW            = 256 / LANE_WIDTH;
  localparam int FRAME_PIX      = OUT_ROWS * OUT_COLS;
  localparam int BYTES_PER_LANE = LANE_WIDTH / 8;
  localparam int LANE_IDX_W     = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int PIX_W          = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;

  localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(PPW - 1);
  localparam logic [PIX_W-1:0]      LAST_PIX  = PIX_W'(FRAME_PIX - 1);

  logic [LANE_IDX_W-1:0] lane_idx;
  logic [PIX_W-1:0]      pix_cnt;
  logic [255:0]          acc;
  logic [255:0]          word_q;
  logic [31:0]           keep_q;
  logic                  last_q;
  logic                  valid_q;
  logic [15:0]           frame_count_q;

  logic                  accept;
  logic                  frame_end;
  logic                  close_word;
  logic [LANE_WIDTH-1:0] lane_val;
  logic [255:0]          next_word;
  logic [31:0]           next_keep;

  assign s_axis_tready = !valid_q || m_axis_tready;
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign frame_end     = (pix_cnt == LAST_PIX);
  assign close_word    = accept && ((lane_idx == LAST_LANE) || frame_end);

  // The word as it would look with the incoming pixel merged in; lanes above lane_idx stay zero.
  always_comb begin
    lane_val = '0;
    lane_val[PIXEL_BIT_WIDTH-1:0] = s_axis_tdata;
    next_word = acc;
    next_word[int'(lane_idx) * LANE_WIDTH +: LANE_WIDTH] = lane_val;
    next_keep = '0;
    for (int i = 0; i < PPW; i++) begin
      if (i <= int'(lane_idx)) next_keep[i * BYTES_PER_LANE +: BYTES_PER_LANE] = '1;
    end
  end

  // A close in the same cycle as a handshake overrides the valid drop, giving 1 pixel/clk.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane_idx      <= '0;
      pix_cnt       <= '0;
      acc           <= '0;
      word_q        <= '0;
      keep_q        <= '0;
      last_q        <= 1'b0;
      valid_q       <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if (valid_q && m_axis_tready) begin
        valid_q <= 1'b0;
        if (last_q) frame_count_q <= frame_count_q + 16'd1;
      end
      if (accept) begin
        pix_cnt <= frame_end ? '0 : pix_cnt + 1'b1;
        if (close_word) begin
          word_q   <= next_word;
          keep_q   <= next_keep;
          last_q   <= frame_end;
          valid_q  <= 1'b1;
          acc      <= '0;
          lane_idx <= '0;
        end else begin
          acc      <= next_word;
          lane_idx <= lane_idx + 1'b1;
        end
      end
    end
  end

  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = word_q;
  assign m_axis_tkeep  = keep_q;
  assign m_axis_tlast  = last_q;
  assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_crop_pixel_packer.sv
// Scoreboard bench for crop_pixel_packer: a 20x20 instance and a 3x7 instance fed random
// pixels, checked against a pixel-queue reference model of the packed word stream.
module tb_crop_pixel_packer;

  typedef struct packed {
    logic [255:0] data;
    logic [31:0]  keep;
    logic         last;
  } word_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  logic         main_valid, main_ready, main_mvalid, main_mready, main_tlast;
  logic [9:0]   main_data;
  logic [255:0] main_tdata;
  logic [31:0]  main_tkeep;
  logic [15:0]  main_fc;

  logic         small_valid, small_ready, small_mvalid, small_mready, small_tlast;
  logic [9:0]   small_data;
  logic [255:0] small_tdata;
  logic [31:0]  small_tkeep;
  logic [15:0]  small_fc;

  crop_pixel_packer dut_main (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(main_valid), .s_axis_tready(main_ready), .s_axis_tdata(main_data),
    .m_axis_tvalid(main_mvalid), .m_axis_tready(main_mready), .m_axis_tdata(main_tdata),
    .m_axis_tkeep(main_tkeep), .m_axis_tlast(main_tlast), .frame_count(main_fc)
  );

  crop_pixel_packer #(.OUT_ROWS(3), .OUT_COLS(7)) dut_small (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(small_valid), .s_axis_tready(small_ready), .s_axis_tdata(small_data),
    .m_axis_tvalid(small_mvalid), .m_axis_tready(small_mready), .m_axis_tdata(small_tdata),
    .m_axis_tkeep(small_tkeep), .m_axis_tlast(small_tlast), .frame_count(small_fc)
  );

  int vectors = 0;
  int miscompares = 0;
  int stalls = 0;
  int words_main = 0;
  int words_small = 0;
  int fidx_main = 0;
  int fidx_small = 0;
  bit ready_rand = 1'b0;
  logic [15:0] exp_fc_main = '0;
  logic [15:0] exp_fc_small = '0;
  logic [31:0] last_keep_small = '0;
  logic [9:0]  cur_main[$];
  logic [9:0]  cur_small[$];
  word_t       exp_main[$];
  word_t       exp_small[$];

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  task automatic flagFail(input string name);
    vectors++;
    miscompares++;
    $display("[TB] FAIL %s: bound expired", name);
  endtask

  // Reference: a word is simply the pixels gathered so far, one per 16-bit lane.
  function automatic word_t buildWord(input logic [9:0] px[$], input bit last);
    word_t w;
    w.data = '0;
    w.keep = '0;
    foreach (px[i]) begin
      w.data[i*16 +: 16] = {6'd0, px[i]};
      w.keep[i*2 +: 2]   = 2'b11;
    end
    w.last = last;
    return w;
  endfunction

  task automatic modelPixel(input bit to_small, input logic [9:0] v);
    if (to_small) begin
      cur_small.push_back(v);
      fidx_small++;
      if (cur_small.size() == 16 || fidx_small == 21) begin
        exp_small.push_back(buildWord(cur_small, fidx_small == 21));
        cur_small.delete();
        if (fidx_small == 21) fidx_small = 0;
      end
    end else begin
      cur_main.push_back(v);
      fidx_main++;
      if (cur_main.size() == 16 || fidx_main == 400) begin
        exp_main.push_back(buildWord(cur_main, fidx_main == 400));
        cur_main.delete();
        if (fidx_main == 400) fidx_main = 0;
      end
    end
  endtask

  // Called at a negedge; holds tvalid until the pixel is taken, returns at the next negedge.
  task automatic applyStimulus(input bit to_small, input logic [9:0] v);
    bit ok = 1'b0;
    if (to_small) begin small_valid = 1'b1; small_data = v; end
    else begin main_valid = 1'b1; main_data = v; end
    for (int c = 0; c < 300; c++) begin
      #3;
      ok = to_small ? small_ready : main_ready;
      @(posedge clk);
      if (ok) break;
      stalls++;
      @(negedge clk);
    end
    if (ok) begin
      modelPixel(to_small, v);
      @(negedge clk);
    end else begin
      flagFail("input_accept_timeout");
    end
  endtask

  task automatic idleInputs();
    main_valid  = 1'b0;
    small_valid = 1'b0;
  endtask

  task automatic drain(input bit to_small);
    for (int c = 0; c < 300; c++) begin
      if ((to_small ? exp_small.size() : exp_main.size()) == 0) break;
      @(negedge clk);
    end
    if ((to_small ? exp_small.size() : exp_main.size()) != 0) flagFail("drain_timeout");
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (ready_rand) main_mready = 1'($urandom_range(0, 1));
  end

  // Main monitor: compares each handshaken word and checks stability across stalls.
  word_t hold_main;
  word_t got_main;
  bit    stall_seen = 1'b0;
  always begin
    @(negedge clk);
    #3;
    if (!reset) begin
      stall_seen = 1'b0;
    end else begin
      if (stall_seen) begin
        checkOutput("stall_hold_valid", 256'(main_mvalid), 256'd1);
        checkOutput("stall_hold_data", main_tdata, hold_main.data);
        checkOutput("stall_hold_keep", 256'(main_tkeep), 256'(hold_main.keep));
        checkOutput("stall_hold_last", 256'(main_tlast), 256'(hold_main.last));
      end
      if (main_mvalid && main_mready) begin
        stall_seen = 1'b0;
        if (exp_main.size() == 0) begin
          flagFail("main_unexpected_word");
        end else begin
          got_main = exp_main.pop_front();
          checkOutput("main_tdata", main_tdata, got_main.data);
          checkOutput("main_tkeep", 256'(main_tkeep), 256'(got_main.keep));
          checkOutput("main_tlast", 256'(main_tlast), 256'(got_main.last));
          if (got_main.last) exp_fc_main = exp_fc_main + 16'd1;
          words_main++;
        end
      end else if (main_mvalid) begin
        stall_seen = 1'b1;
        hold_main = '{data: main_tdata, keep: main_tkeep, last: main_tlast};
      end else begin
        stall_seen = 1'b0;
      end
    end
  end

  word_t got_small;
  always begin
    @(negedge clk);
    #3;
    if (reset && small_mvalid && small_mready) begin
      if (exp_small.size() == 0) begin
        flagFail("small_unexpected_word");
      end else begin
        got_small = exp_small.pop_front();
        checkOutput("small_tdata", small_tdata, got_small.data);
        checkOutput("small_tkeep", 256'(small_tkeep), 256'(got_small.keep));
        checkOutput("small_tlast", 256'(small_tlast), 256'(got_small.last));
        if (got_small.last) exp_fc_small = exp_fc_small + 16'd1;
        last_keep_small = small_tkeep;
        words_small++;
      end
    end
  end

  task automatic checkResetOutputs();
    checkOutput("rst_tvalid", 256'(main_mvalid), 256'd0);
    checkOutput("rst_tdata", main_tdata, 256'd0);
    checkOutput("rst_tkeep", 256'(main_tkeep), 256'd0);
    checkOutput("rst_tlast", 256'(main_tlast), 256'd0);
    checkOutput("rst_frame_count", 256'(main_fc), 256'd0);
  endtask

  initial begin
    bit got_valid;
    int w0;
    reset        = 1'b0;
    main_valid   = 1'b0;
    main_data    = '0;
    small_valid  = 1'b0;
    small_data   = '0;
    main_mready  = 1'b1;
    small_mready = 1'b1;
    #1;
    checkResetOutputs();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("ready_after_reset", 256'(main_ready), 256'd1);
    @(negedge clk);

    $display("[TB] frame of index-valued pixels");
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, 10'(i % 1024));
    idleInputs();
    drain(1'b0);
    checkOutput("t1_words", 256'(words_main), 256'd25);
    checkOutput("t1_frame_count", 256'(main_fc), 256'(exp_fc_main));
    checkOutput("t1_frame_count_abs", 256'(main_fc), 256'd1);

    $display("[TB] 3x7 frame with padded final word");
    for (int i = 0; i < 21; i++) applyStimulus(1'b1, 10'($urandom));
    idleInputs();
    drain(1'b1);
    checkOutput("t2_words", 256'(words_small), 256'd2);
    checkOutput("t2_pad_keep", 256'(last_keep_small), 256'h3FF);
    checkOutput("t2_frame_count", 256'(small_fc), 256'd1);

    $display("[TB] downstream stall after first word");
    main_mready = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) applyStimulus(1'b0, 10'($urandom));
      end
      begin
        got_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (main_mvalid) begin got_valid = 1'b1; break; end
        end
        if (!got_valid) flagFail("t3_wait_word0");
        for (int k = 0; k < 10; k++) begin
          #1;
          checkOutput("t3_s_tready_low", 256'(main_ready), 256'd0);
          @(negedge clk);
        end
        main_mready = 1'b1;
      end
    join
    idleInputs();
    drain(1'b0);
    checkOutput("t3_words", 256'(words_main), 256'd50);
    checkOutput("t3_frame_count", 256'(main_fc), 256'(exp_fc_main));

    $display("[TB] three back-to-back frames");
    stalls = 0;
    w0 = words_main;
    for (int i = 0; i < 1200; i++) applyStimulus(1'b0, 10'($urandom));
    idleInputs();
    checkOutput("t4_no_stalls", 256'(stalls), 256'd0);
    drain(1'b0);
    checkOutput("t4_words", 256'(words_main - w0), 256'd75);
    checkOutput("t4_frame_count", 256'(main_fc), 256'(exp_fc_main));

    $display("[TB] reset mid-frame");
    for (int i = 0; i < 37; i++) applyStimulus(1'b0, 10'($urandom));
    idleInputs();
    reset = 1'b0;
    #1;
    checkResetOutputs();
    exp_main.delete();
    cur_main.delete();
    fidx_main = 0;
    exp_fc_main = '0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("t5_ready_after_reset", 256'(main_ready), 256'd1);
    @(negedge clk);
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, 10'($urandom));
    idleInputs();
    drain(1'b0);
    checkOutput("t5_frame_count", 256'(main_fc), 256'd1);

    $display("[TB] random backpressure and input gaps");
    ready_rand = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idleInputs();
        @(negedge clk);
      end
      applyStimulus(1'b0, 10'($urandom));
    end
    idleInputs();
    ready_rand = 1'b0;
    @(negedge clk);
    main_mready = 1'b1;
    drain(1'b0);
    checkOutput("t7_frame_count", 256'(main_fc), 256'(exp_fc_main));

    $display("[TB] frame counter wrap");
    force dut_main.frame_count_q = 16'hFFFF;
    #1;
    release dut_main.frame_count_q;
    exp_fc_main = 16'hFFFF;
    @(negedge clk);
    checkOutput("t6_preload", 256'(main_fc), 256'hFFFF);
    for (int i = 0; i < 400; i++) applyStimulus(1'b0, 10'($urandom));
    idleInputs();
    drain(1'b0);
    checkOutput("t6_wrap_model", 256'(main_fc), 256'(exp_fc_main));
    checkOutput("t6_wrap_zero", 256'(main_fc), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
